// File: rtl/branch_cmp_if.sv
// Operand/result bundle between the execute-stage operand mux and the branch comparator.
// The master drives the operands and opcode. The slave returns the registered result.
interface branch_cmp_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;
  logic [2:0]      cmp_op;
  logic            out_valid;
  logic            b;
  logic            err;

  modport master (
    output in_valid, rs1_d, rs2_d, cmp_op,
    input  out_valid, b, err
  );

  modport slave (
    input  in_valid, rs1_d, rs2_d, cmp_op,
    output out_valid, b, err
  );
endinterface

// File: rtl/branch_cmp.sv
// RV32I branch-condition comparator (BEQ/BNE/BLT/BGE/BLTU/BGEU) with a one-cycle registered result.
// Optional feature macro: CMP_ILLEGAL_OP_EN flags reserved opcodes on err; otherwise err is tied to 0.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_cmp_if.slave bus
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LT  = 3'd2,
    OP_GE  = 3'd3,
    OP_LTU = 3'd4,
    OP_GEU = 3'd5
  } cmp_op_e;

  logic eq;
  logic lt_u;
  logic lt_s;
  logic b_d;
  logic b_q;
  logic out_valid_q;

  // One equality and one magnitude comparator; signed less-than reuses the unsigned result
  // whenever the sign bits agree.
  assign eq   = (bus.rs1_d == bus.rs2_d);
  assign lt_u = (bus.rs1_d <  bus.rs2_d);
  assign lt_s = (bus.rs1_d[XLEN-1] != bus.rs2_d[XLEN-1]) ? bus.rs1_d[XLEN-1] : lt_u;

  always_comb begin
    b_d = 1'b0;
    case (bus.cmp_op)
      OP_EQ:   b_d = eq;
      OP_NE:   b_d = ~eq;
      OP_LT:   b_d = lt_s;
      OP_GE:   b_d = ~lt_s;
      OP_LTU:  b_d = lt_u;
      OP_GEU:  b_d = ~lt_u;
      default: b_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      b_q         <= b_d;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.b         = b_q;
  assign bus.out_valid = out_valid_q;

`ifdef CMP_ILLEGAL_OP_EN
  logic err_d;
  logic err_q;

  // Opcodes 6 and 7 are the only ones with both upper bits set.
  assign err_d = bus.in_valid & bus.cmp_op[2] & bus.cmp_op[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_branch_cmp.sv
// Scoreboard bench for branch_cmp: each driven request pushes its expected result,
// which is popped and compared when the registered output appears one cycle later.
module tb_branch_cmp;

  typedef struct {
    string tag;
    logic  valid;
    logic  b;
    logic  err;
  } expect_t;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   mismatchCount;
  expect_t scoreQ[$];

  branch_cmp_if #(.XLEN(32)) bus ();

  branch_cmp #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Reference model written with the plain Verilog operators.
  function automatic logic refB(input logic [31:0] a, input logic [31:0] c, input logic [2:0] op);
    case (op)
      3'd0:    return a == c;
      3'd1:    return a != c;
      3'd2:    return $signed(a) <  $signed(c);
      3'd3:    return $signed(a) >= $signed(c);
      3'd4:    return a <  c;
      3'd5:    return a >= c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic refErr(input logic valid, input logic [2:0] op);
`ifdef CMP_ILLEGAL_OP_EN
    return valid && (op >= 3'd6);
`else
    return 1'b0 & valid & op[0];
`endif
  endfunction

  task automatic popAndCheck();
    expect_t e;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput({e.tag, ".out_valid"}, bus.out_valid, e.valid);
      if (e.valid) checkOutput({e.tag, ".b"}, bus.b, e.b);
      checkOutput({e.tag, ".err"}, bus.err, e.err);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] c,
                               input logic [2:0] op);
    expect_t e;
    @(negedge clk);
    popAndCheck();
    bus.in_valid = valid;
    bus.rs1_d    = a;
    bus.rs2_d    = c;
    bus.cmp_op   = op;
    e.tag   = $sformatf("v%0b_%08h_%08h_op%0d", valid, a, c, op);
    e.valid = valid;
    e.b     = refB(a, c, op);
    e.err   = refErr(valid, op);
    scoreQ.push_back(e);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    popAndCheck();
  endtask

  logic [31:0] sweepVals [5];

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    sweepVals[0] = 32'd10;
    sweepVals[1] = 32'd3;
    sweepVals[2] = 32'hFFFF_FFFC;
    sweepVals[3] = 32'd4;
    sweepVals[4] = 32'hFFFF_FFF0;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.rs1_d    = '0;
    bus.rs2_d    = '0;
    bus.cmp_op   = 3'd0;

    #12;
    checkOutput("reset.b", bus.b, 1'b0);
    checkOutput("reset.out_valid", bus.out_valid, 1'b0);
    checkOutput("reset.err", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    applyStimulus(1'b1, 32'd10, 32'd10, 3'd0);
    applyStimulus(1'b1, 32'd10, 32'd10, 3'd1);
    applyStimulus(1'b1, 32'd10, 32'd10, 3'd3);
    applyStimulus(1'b1, 32'd10, 32'd10, 3'd5);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'd3, 3'd2);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'd3, 3'd4);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'd3, 3'd3);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'd3, 3'd5);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 3'd2);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 3'd4);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 3'd3);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 3'd5);
    applyStimulus(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'd2);
    applyStimulus(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'd4);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 3'd3);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 3'd5);

    // Reserved opcodes, with and without a valid request.
    applyStimulus(1'b1, 32'd5, 32'd5, 3'd6);
    applyStimulus(1'b1, 32'd1, 32'd2, 3'd7);
    applyStimulus(1'b0, 32'd5, 32'd5, 3'd6);
    applyStimulus(1'b1, 32'd5, 32'd5, 3'd0);

    // Full sweep, with every seventh request marked invalid.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        for (int op = 0; op < 6; op++) begin
          applyStimulus(((i * 30 + j * 6 + op) % 7) != 6, sweepVals[i], sweepVals[j], 3'(op));
        end
      end
    end
    drain();

    // Asynchronous reset between clock edges discards the in-flight result.
    applyStimulus(1'b1, 32'd10, 32'd10, 3'd0);
    scoreQ.delete();
    @(posedge clk);
    #2;
    checkOutput("prereset.out_valid", bus.out_valid, 1'b1);
    checkOutput("prereset.b", bus.b, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncreset.b", bus.b, 1'b0);
    checkOutput("asyncreset.out_valid", bus.out_valid, 1'b0);
    checkOutput("asyncreset.err", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Operation resumes normally after release.
    applyStimulus(1'b1, 32'd3, 32'hFFFF_FFFC, 3'd2);
    applyStimulus(1'b1, 32'd3, 32'hFFFF_FFFC, 3'd4);
    applyStimulus(1'b1, 32'd4, 32'd3, 3'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
